// File: rtl/issue_ctrl_pkg.sv
// Shared types for the in-order issue controller: register index, FSM states,
// and the holding-slot layout.
package issue_ctrl_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int PAYLOAD_W = 64;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } issue_state_e;

    typedef struct packed {
        rf_addr_t               rs1;
        rf_addr_t               rs2;
        rf_addr_t               rd;
        logic                   uses_rs1;
        logic                   uses_rs2;
        logic                   writes_rd;
        logic [PAYLOAD_W-1:0]   payload;
    } issue_slot_t;

    // x0 is hardwired, so it never waits on the scoreboard.
    function automatic logic src_blocked(input logic uses, input rf_addr_t idx, input logic busy);
        return uses && (idx != '0) && busy;
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode / scoreboard / execute signal bundle around issue_ctrl.
// slave is the issue_ctrl side, master is the surrounding pipeline.
interface issue_ctrl_if
    import issue_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) ();

    logic                   dec_valid_i;
    logic                   dec_ready_o;
    rf_addr_t               dec_rs1_i;
    rf_addr_t               dec_rs2_i;
    rf_addr_t               dec_rd_i;
    logic                   dec_uses_rs1_i;
    logic                   dec_uses_rs2_i;
    logic                   dec_writes_rd_i;
    logic [PAYLOAD_W-1:0]   dec_payload_i;

    rf_addr_t               sb_query_1_o;
    rf_addr_t               sb_query_2_o;
    logic                   sb_busy_1_i;
    logic                   sb_busy_2_i;
    rf_addr_t               sb_reserve_o;

    logic                   ex_valid_o;
    logic                   ex_ready_i;
    logic [PAYLOAD_W-1:0]   ex_payload_o;
    rf_addr_t               ex_rd_o;

    logic                   flush_i;
    logic                   stat_clear_i;
    logic [STALL_CNT_W-1:0] stall_cycles_o;

    modport master (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
        output dec_uses_rs1_i, dec_uses_rs2_i, dec_writes_rd_i, dec_payload_i,
        output sb_busy_1_i, sb_busy_2_i, ex_ready_i, flush_i, stat_clear_i,
        input  dec_ready_o, sb_query_1_o, sb_query_2_o, sb_reserve_o,
        input  ex_valid_o, ex_payload_o, ex_rd_o, stall_cycles_o
    );

    modport slave (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
        input  dec_uses_rs1_i, dec_uses_rs2_i, dec_writes_rd_i, dec_payload_i,
        input  sb_busy_1_i, sb_busy_2_i, ex_ready_i, flush_i, stat_clear_i,
        output dec_ready_o, sb_query_1_o, sb_query_2_o, sb_reserve_o,
        output ex_valid_o, ex_payload_o, ex_rd_o, stall_cycles_o
    );

endinterface

// File: rtl/issue_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Generic enough for any performance event counter.
module issue_ctrl_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// In-order single-issue controller: holds one decoded instruction, stalls on
// RAW hazards reported by the scoreboard, issues to execute and reserves rd.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   EMPTY | slot free; decode is accepted unless flushing
//   HELD  | slot holds an instruction waiting on operands or execute
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input logic          clk,
    input logic          reset_n,
    issue_ctrl_if.slave  bus
);

    issue_state_e           state;
    issue_slot_t            slot;
    issue_slot_t            dec_slot;
    logic                   held_valid;
    logic                   hazard;
    logic                   ex_valid;
    logic                   fire;
    logic                   dec_ready;
    logic                   accept;
    logic                   stall_inc;
    logic [STALL_CNT_W-1:0] stall_count;

    always_comb begin
        held_valid = (state == HELD);
        hazard     = held_valid &&
                     (src_blocked(slot.uses_rs1, slot.rs1, bus.sb_busy_1_i) ||
                      src_blocked(slot.uses_rs2, slot.rs2, bus.sb_busy_2_i));
        ex_valid   = held_valid && !hazard && !bus.flush_i;
        fire       = ex_valid && bus.ex_ready_i;
        dec_ready  = !bus.flush_i && (!held_valid || fire);
        accept     = bus.dec_valid_i && dec_ready;
        stall_inc  = hazard && !bus.flush_i;
    end

    always_comb begin
        dec_slot           = '0;
        dec_slot.rs1       = bus.dec_rs1_i;
        dec_slot.rs2       = bus.dec_rs2_i;
        dec_slot.rd        = bus.dec_rd_i;
        dec_slot.uses_rs1  = bus.dec_uses_rs1_i;
        dec_slot.uses_rs2  = bus.dec_uses_rs2_i;
        dec_slot.writes_rd = bus.dec_writes_rd_i;
        dec_slot.payload   = bus.dec_payload_i;
    end

    // Everything toward execute and the scoreboard comes from the slot, never
    // straight from the decode fields.
    assign bus.dec_ready_o    = dec_ready;
    assign bus.ex_valid_o     = ex_valid;
    assign bus.ex_payload_o   = slot.payload;
    assign bus.ex_rd_o        = (held_valid && slot.writes_rd) ? slot.rd : '0;
    assign bus.sb_reserve_o   = (fire && slot.writes_rd) ? slot.rd : '0;
    assign bus.sb_query_1_o   = held_valid ? slot.rs1 : '0;
    assign bus.sb_query_2_o   = held_valid ? slot.rs2 : '0;
    assign bus.stall_cycles_o = stall_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            slot  <= '0;
        end else if (bus.flush_i) begin
            state <= EMPTY;
            slot  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= HELD;
                        slot  <= dec_slot;
                    end
                end
                HELD: begin
                    // In HELD an accept implies a fire, so the slot reloads.
                    if (accept) begin
                        slot <= dec_slot;
                    end else if (fire) begin
                        state <= EMPTY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    issue_ctrl_sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bus.stat_clear_i),
        .inc     (stall_inc),
        .count   (stall_count)
    );

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed vectors, hand sequences for the multi-cycle
// cases, then random traffic against a queue-based reference model.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    issue_ctrl_if #(.STALL_CNT_W(CW)) bus ();
    issue_ctrl #(.STALL_CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    logic        use_sb    = 1'b0;
    logic        busy1_drv = 1'b0;
    logic        busy2_drv = 1'b0;
    logic [31:0] sb_bits   = '0;
    int          timer[32];

    assign bus.sb_busy_1_i = use_sb ? sb_bits[bus.sb_query_1_o] : busy1_drv;
    assign bus.sb_busy_2_i = use_sb ? sb_bits[bus.sb_query_2_o] : busy2_drv;

    typedef struct {
        rf_addr_t    rs1, rs2, rd;
        bit          u1, u2, wr;
        logic [63:0] payload;
    } instr_t;

    // field order: nm, rs1, rs2, rd, u1, u2, wr, b1, b2, rdy, fl, e_v, e_dr, e_res
    typedef struct {
        string nm;
        int    rs1, rs2, rd;
        bit    u1, u2, wr, b1, b2, rdy, fl, e_v, e_dr;
        int    e_res;
    } vec_t;

    instr_t m_q[$];
    int     m_cnt;
    bit     p_flush, p_fire, p_acc, p_inc, p_clr;
    int     p_res;
    instr_t p_ins;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input int rs1, input int rs2, input int rd,
                                  input bit u1, input bit u2, input bit wr);
        instr_t i;
        i.rs1 = rf_addr_t'(rs1);
        i.rs2 = rf_addr_t'(rs2);
        i.rd  = rf_addr_t'(rd);
        i.u1 = u1; i.u2 = u2; i.wr = wr;
        i.payload = {$urandom, $urandom};
        return i;
    endfunction

    task automatic drive(input logic v, input instr_t i);
        bus.dec_valid_i     = v;
        bus.dec_rs1_i       = i.rs1;
        bus.dec_rs2_i       = i.rs2;
        bus.dec_rd_i        = i.rd;
        bus.dec_uses_rs1_i  = i.u1;
        bus.dec_uses_rs2_i  = i.u2;
        bus.dec_writes_rd_i = i.wr;
        bus.dec_payload_i   = i.payload;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_stats();
        cyc(); bus.stat_clear_i = 1'b1;
        cyc(); bus.stat_clear_i = 1'b0;
    endtask

    function automatic bit operand_busy(input bit used, input rf_addr_t r);
        return used && (r != 0) && sb_bits[r];
    endfunction

    // Apply the decisions recorded last cycle to the model and scoreboard.
    task automatic commit();
        if (p_flush) begin
            m_q.delete();
        end else begin
            if (p_fire) void'(m_q.pop_front());
            if (p_acc) m_q.push_back(p_ins);
        end
        for (int r = 1; r < 32; r++) begin
            if (timer[r] > 0) begin
                timer[r]--;
                if (timer[r] == 0) sb_bits[r] = 1'b0;
            end
        end
        if (p_res != 0) begin
            sb_bits[p_res] = 1'b1;
            timer[p_res]   = int'($urandom_range(1, 4));
        end
        if (p_clr) m_cnt = 0;
        else if (p_inc) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    endtask

    initial begin
        vec_t   vecs[9];
        instr_t ins[4];
        instr_t a, b, x, y, z;

        vecs[0] = '{"plain_fire", 3, 4, 5, 1, 1, 1, 0, 0, 1, 0, 1, 1, 5};
        vecs[1] = '{"ex_backpr",  3, 4, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0};
        vecs[2] = '{"raw_rs1",    3, 4, 5, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[3] = '{"raw_rs2",    3, 12, 5, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[4] = '{"x0_unused",  0, 7, 9, 1, 0, 1, 1, 1, 1, 0, 1, 1, 9};
        vecs[5] = '{"no_wr",      3, 4, 6, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0};
        vecs[6] = '{"flush_ok",   3, 4, 5, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
        vecs[7] = '{"flush_haz",  9, 4, 5, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0};
        vecs[8] = '{"rs1_unused", 2, 2, 3, 0, 1, 1, 1, 0, 1, 0, 1, 1, 3};

        for (int r = 0; r < 32; r++) timer[r] = 0;
        drive(1'b0, mk(0, 0, 0, 0, 0, 0));
        bus.ex_ready_i = 1'b0; bus.flush_i = 1'b0; bus.stat_clear_i = 1'b0;

        #12 reset_n = 1'b1;
        #1;
        chk("rst_ex_valid",  64'(bus.ex_valid_o), 64'(0));
        chk("rst_dec_ready", 64'(bus.dec_ready_o), 64'(1));
        chk("rst_reserve",   64'(bus.sb_reserve_o), 64'(0));
        chk("rst_query1",    64'(bus.sb_query_1_o), 64'(0));
        chk("rst_query2",    64'(bus.sb_query_2_o), 64'(0));
        chk("rst_stall",     64'(bus.stall_cycles_o), 64'(0));
        chk("rst_ex_rd",     64'(bus.ex_rd_o), 64'(0));

        // Independent stream, one fire per cycle.
        for (int k = 0; k < 4; k++) ins[k] = mk(k + 10, k + 20, k + 1, 1, 1, 1);
        cyc(); bus.ex_ready_i = 1'b1; drive(1'b1, ins[0]);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k < 4) drive(1'b1, ins[k]); else bus.dec_valid_i = 1'b0;
            smp();
            chk("stream_valid",   64'(bus.ex_valid_o), 64'(1));
            chk("stream_reserve", 64'(bus.sb_reserve_o), 64'(ins[k-1].rd));
            chk("stream_payload", bus.ex_payload_o, ins[k-1].payload);
            chk("stream_ready",   64'(bus.dec_ready_o), 64'(1));
        end
        cyc(); smp();
        chk("stream_drained", 64'(bus.ex_valid_o), 64'(0));
        chk("stream_stall",   64'(bus.stall_cycles_o), 64'(0));

        // RAW stall: A writes x5, B reads x5; writeback three cycles after A fires.
        a = mk(1, 2, 5, 0, 0, 1);
        b = mk(5, 0, 6, 1, 0, 1);
        cyc(); drive(1'b1, a);
        cyc(); drive(1'b1, b); smp();
        chk("raw_a_reserve", 64'(bus.sb_reserve_o), 64'(5));
        for (int k = 0; k < 3; k++) begin
            cyc(); bus.dec_valid_i = 1'b0; busy1_drv = 1'b1; smp();
            chk("raw_b_stalled", 64'(bus.ex_valid_o), 64'(0));
            chk("raw_query",     64'(bus.sb_query_1_o), 64'(5));
        end
        cyc(); busy1_drv = 1'b0; smp();
        chk("raw_b_valid",   64'(bus.ex_valid_o), 64'(1));
        chk("raw_b_reserve", 64'(bus.sb_reserve_o), 64'(6));
        chk("raw_stall_cnt", 64'(bus.stall_cycles_o), 64'(3));
        cyc(); smp();
        chk("raw_drained", 64'(bus.ex_valid_o), 64'(0));

        // Execute backpressure.
        clear_stats();
        x = mk(1, 2, 7, 1, 1, 1);
        y = mk(3, 4, 8, 1, 1, 1);
        cyc(); bus.ex_ready_i = 1'b0; drive(1'b1, x);
        for (int k = 0; k < 5; k++) begin
            cyc(); drive(1'b1, y); smp();
            chk("bp_valid",   64'(bus.ex_valid_o), 64'(1));
            chk("bp_ready",   64'(bus.dec_ready_o), 64'(0));
            chk("bp_reserve", 64'(bus.sb_reserve_o), 64'(0));
        end
        cyc(); bus.ex_ready_i = 1'b1; smp();
        chk("bp_fire_reserve", 64'(bus.sb_reserve_o), 64'(7));
        chk("bp_fire_ready",   64'(bus.dec_ready_o), 64'(1));
        cyc(); bus.dec_valid_i = 1'b0; smp();
        chk("bp_y_reserve", 64'(bus.sb_reserve_o), 64'(8));
        chk("bp_y_payload", bus.ex_payload_o, y.payload);
        chk("bp_stall",     64'(bus.stall_cycles_o), 64'(0));

        // Flush while stalled on x9.
        z = mk(9, 0, 10, 1, 0, 1);
        cyc(); drive(1'b1, z); busy1_drv = 1'b1;
        cyc(); bus.dec_valid_i = 1'b0; smp();
        chk("fl_stalled", 64'(bus.ex_valid_o), 64'(0));
        cyc(); bus.flush_i = 1'b1; drive(1'b1, y); smp();
        chk("fl_ready",   64'(bus.dec_ready_o), 64'(0));
        chk("fl_reserve", 64'(bus.sb_reserve_o), 64'(0));
        chk("fl_valid",   64'(bus.ex_valid_o), 64'(0));
        cyc(); bus.flush_i = 1'b0; bus.dec_valid_i = 1'b0; busy1_drv = 1'b0; smp();
        chk("fl_after_ready", 64'(bus.dec_ready_o), 64'(1));
        chk("fl_after_query", 64'(bus.sb_query_1_o), 64'(0));
        chk("fl_after_valid", 64'(bus.ex_valid_o), 64'(0));

        // Stall counter saturation and clear-beats-increment.
        clear_stats();
        cyc(); drive(1'b1, z); busy1_drv = 1'b1;
        cyc(); bus.dec_valid_i = 1'b0;
        repeat (20) cyc();
        smp();
        chk("sat_value", 64'(bus.stall_cycles_o), 64'(CMAX));
        cyc(); bus.stat_clear_i = 1'b1;
        cyc(); bus.stat_clear_i = 1'b0; smp();
        chk("sat_clear", 64'(bus.stall_cycles_o), 64'(0));
        cyc(); bus.flush_i = 1'b1;
        cyc(); bus.flush_i = 1'b0; busy1_drv = 1'b0;

        // Reset in the middle of a held instruction.
        cyc(); bus.ex_ready_i = 1'b0; drive(1'b1, mk(1, 2, 11, 1, 1, 1));
        cyc(); bus.dec_valid_i = 1'b0; smp();
        chk("mid_rst_held", 64'(bus.ex_valid_o), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid",   64'(bus.ex_valid_o), 64'(0));
        chk("mid_rst_reserve", 64'(bus.sb_reserve_o), 64'(0));
        chk("mid_rst_query",   64'(bus.sb_query_1_o), 64'(0));
        #1 reset_n = 1'b1;
        bus.ex_ready_i = 1'b1;
        cyc(); smp();
        chk("mid_rst_after_valid", 64'(bus.ex_valid_o), 64'(0));
        chk("mid_rst_after_ready", 64'(bus.dec_ready_o), 64'(1));

        // Directed vectors: load from empty, then apply the record's conditions.
        foreach (vecs[i]) begin
            cyc();
            bus.flush_i = 1'b0; bus.ex_ready_i = 1'b0;
            busy1_drv = 1'b0; busy2_drv = 1'b0;
            drive(1'b1, mk(vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                           vecs[i].u1, vecs[i].u2, vecs[i].wr));
            cyc();
            bus.dec_valid_i = 1'b0;
            busy1_drv = vecs[i].b1; busy2_drv = vecs[i].b2;
            bus.ex_ready_i = vecs[i].rdy; bus.flush_i = vecs[i].fl;
            smp();
            chk({vecs[i].nm, "_valid"},   64'(bus.ex_valid_o), 64'(vecs[i].e_v));
            chk({vecs[i].nm, "_ready"},   64'(bus.dec_ready_o), 64'(vecs[i].e_dr));
            chk({vecs[i].nm, "_reserve"}, 64'(bus.sb_reserve_o), 64'(vecs[i].e_res));
            chk({vecs[i].nm, "_query1"},  64'(bus.sb_query_1_o), 64'(vecs[i].rs1));
            chk({vecs[i].nm, "_query2"},  64'(bus.sb_query_2_o), 64'(vecs[i].rs2));
            chk({vecs[i].nm, "_ex_rd"},   64'(bus.ex_rd_o), 64'(vecs[i].wr ? vecs[i].rd : 0));
            cyc(); bus.flush_i = 1'b1; busy1_drv = 1'b0; busy2_drv = 1'b0;
            cyc(); bus.flush_i = 1'b0;
        end

        // Random traffic against the reference model with a live scoreboard.
        clear_stats();
        m_cnt = 0;
        p_flush = 0; p_fire = 0; p_acc = 0; p_inc = 0; p_clr = 0; p_res = 0;
        sb_bits = '0;
        use_sb = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bit     held, blocked, e_v, e_fire, e_dr;
            int     e_res;
            instr_t h, n;
            cyc();
            commit();
            n = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive(($urandom_range(0, 3) != 0), n);
            bus.ex_ready_i   = ($urandom_range(0, 3) != 0);
            bus.flush_i      = ($urandom_range(0, 15) == 0);
            bus.stat_clear_i = ($urandom_range(0, 31) == 0);
            smp();
            held    = (m_q.size() > 0);
            h       = held ? m_q[0] : mk(0, 0, 0, 0, 0, 0);
            blocked = held && (operand_busy(h.u1, h.rs1) || operand_busy(h.u2, h.rs2));
            e_v     = held && !blocked && !bus.flush_i;
            e_fire  = e_v && bus.ex_ready_i;
            e_dr    = !bus.flush_i && (!held || e_fire);
            e_res   = (e_fire && h.wr) ? int'(h.rd) : 0;
            chk("rnd_valid",   64'(bus.ex_valid_o), 64'(e_v));
            chk("rnd_ready",   64'(bus.dec_ready_o), 64'(e_dr));
            chk("rnd_reserve", 64'(bus.sb_reserve_o), 64'(e_res));
            chk("rnd_query1",  64'(bus.sb_query_1_o), 64'(held ? int'(h.rs1) : 0));
            chk("rnd_query2",  64'(bus.sb_query_2_o), 64'(held ? int'(h.rs2) : 0));
            chk("rnd_stall",   64'(bus.stall_cycles_o), 64'(m_cnt));
            if (e_v) begin
                chk("rnd_payload", bus.ex_payload_o, h.payload);
                chk("rnd_ex_rd",   64'(bus.ex_rd_o), 64'(h.wr ? int'(h.rd) : 0));
            end
            p_flush = bus.flush_i;
            p_fire  = e_fire;
            p_acc   = bus.dec_valid_i && e_dr;
            p_ins   = n;
            p_res   = e_res;
            p_inc   = blocked && !bus.flush_i;
            p_clr   = bus.stat_clear_i;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

In-order single-issue controller between decode and execute. It holds one decoded instruction, checks its source registers for RAW hazards by querying the scoreboard, and stalls until they are clear. It then issues the instruction to execute and drives the scoreboard reservation for its rd. It is the requesting side of the scoreboard query/reserve protocol and counts hazard stall cycles for performance monitoring.

## Interface
- PAYLOAD_W, 64, width of the opaque decoded-instruction bundle passed from decode to execute
- STALL_CNT_W, 16, width of the saturating stall counter
- clk  in  1  core clock
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- dec_valid_i  in  1  decode presents an instruction
- dec_ready_o  out  1  issue_ctrl accepts it this cycle
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  RFADDR each  register indices
- dec_uses_rs1_i, dec_uses_rs2_i, dec_writes_rd_i  in  1 each  operand-use and rd-write flags
- dec_payload_i  in  PAYLOAD_W  decoded bundle
- sb_query_1_o, sb_query_2_o  out  RFADDR each  scoreboard query indices
- sb_busy_1_i, sb_busy_2_i  in  1 each  scoreboard answers (1 = register has a write in flight)
- sb_reserve_o  out  RFADDR  rd to mark in flight; 0 = no reservation
- ex_valid_o  out  1  instruction offered to execute
- ex_ready_i  in  1  execute accepts
- ex_payload_o  out  PAYLOAD_W  held bundle
- ex_rd_o  out  RFADDR  held rd (0 when writes_rd clear)
- flush_i  in  1  pipeline flush; drop the held instruction
- stat_clear_i  in  1  synchronous clear of the stall counter
- stall_cycles_o  out  STALL_CNT_W  saturating count of hazard stall cycles

## Operation
- One holding slot: held_valid, rs1, rs2, rd, use flags, payload. FSM states: EMPTY (held_valid=0) and HELD (held_valid=1).
- sb_query_1_o/2_o = held rs1/rs2, driven combinationally from the slot and held stable while in HELD. In EMPTY they output 0.
- hazard = held_valid && ((uses_rs1 && rs1!=0 && sb_busy_1_i) || (uses_rs2 && rs2!=0 && sb_busy_2_i)). x0 never causes a hazard.
- ex_valid_o = held_valid && !hazard && !flush_i.
- fire = ex_valid_o && ex_ready_i.
- dec_ready_o = !flush_i && (!held_valid || fire).
- accept = dec_valid_i && dec_ready_o.
- sb_reserve_o = (fire && writes_rd) ? rd : 0. It is asserted only in the fire cycle.
- Transitions:
  - EMPTY→HELD on accept.
  - HELD→HELD on fire with accept (back-to-back; the slot reloads).
  - HELD→EMPTY on fire without accept, or on flush_i.
- flush_i has priority over everything. The slot is cleared, there is no fire, no reserve and no accept in that cycle.
- Stall counter increments when held_valid && hazard && !flush_i and saturates at all-ones. stat_clear_i clears it; clear wins over an increment in the same cycle.
- Busy bits are set only by this block's reservations and cleared by writeback. Therefore, once ex_valid_o rises for a held instruction, it stays high until fire or flush.
- A reservation and a writeback to the same register in the same cycle are resolved inside the scoreboard. issue_ctrl does not gate this case.

## Timing
- Reset values: held_valid=0, state EMPTY, ex_valid_o=0, sb_reserve_o=0, sb_query_*_o=0, stall_cycles_o=0, ex_rd_o=0. dec_ready_o=1 when reset deasserts.
- Reset asserted mid-operation drops the held instruction immediately with no reservation.
- Hazard-free latency: accepted at edge N, so ex_valid_o is high in cycle N+1. Throughput is one instruction per cycle when ex_ready_i=1.
- Dependent back-to-back: A fires in cycle N with reserve=rd. B, which reads that rd, is accepted in the same cycle. In N+1 the scoreboard bit is set, so B stalls.
- Writeback clears the bit at edge W, so B's ex_valid_o rises in cycle W+1.
- All outputs except the slot registers and stall_cycles_o are combinational from the registered slot, sb_busy_*_i, ex_ready_i, dec_valid_i and flush_i. There are no combinational paths from dec_*_i fields to ex_*_o.

## Structure
- The imhotep package gains:
  - typedef enum issue_state_e {EMPTY, HELD}
  - a packed struct issue_slot_t holding rs1, rs2, rd, the three flags and the payload (PAYLOAD_W supplied as a package parameter)
- One sub-module is natural: sat_counter (parameterised width, increment, synchronous clear, saturation). It is reusable for other performance counters.

## Test plan
- Independent stream: 4 instructions, no busy bits, ex_ready_i=1 → ex_valid_o high from cycle 1, one fire per cycle, sb_reserve_o = each rd in its fire cycle, stall_cycles_o=0.
- RAW stall: A writes x5; B reads rs1=x5. Writeback clears x5 three cycles after A's fire → B's ex_valid_o stays low for 3 cycles, rises the cycle after the clear, stall_cycles_o=3.
- x0 and unused operands: rs1=0 with busy_1=1, and rs2=7 with uses_rs2=0 and busy_2=1 → no stall, fire immediately.
- Execute backpressure: ex_ready_i low for 5 cycles with no hazard → ex_valid_o held high, dec_ready_o=0, sb_reserve_o=0 until ex_ready_i rises, stall counter unchanged.
- Flush while stalled on x9 → slot cleared next edge, no reservation of rd, dec_ready_o=0 during the flush cycle and 1 the following cycle.
- Counter saturation with STALL_CNT_W=4: 20 stall cycles → stall_cycles_o=15. stat_clear_i in the same cycle as a stall → 0.
